// File: rtl/fpu_pkg.sv
// Shared FPU constants and width helpers for the multiply pipe and the future add/divide pipes.
package fpu_pkg;

  localparam logic [1:0] RC_RN = 2'b00;
  localparam logic [1:0] RC_RD = 2'b01;
  localparam logic [1:0] RC_RU = 2'b10;
  localparam logic [1:0] RC_RZ = 2'b11;

  localparam int FLAG_INX = 0;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_DEN = 3;
  localparam int FLAG_INV = 4;

  // Widest supported {sign, exp, frac}; callers slice the low bits they need.
  localparam int FP_MAX_W = 128;

  function automatic int unsigned exp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  function automatic int unsigned exp_all_ones(input int unsigned exp_w);
    return (32'd1 << exp_w) - 32'd1;
  endfunction

  function automatic logic [FP_MAX_W-1:0] max_finite(input int unsigned exp_w,
                                                     input int unsigned frac_w);
    logic [FP_MAX_W-1:0] ones_v;
    ones_v = (FP_MAX_W'(1) << (exp_w + frac_w)) - FP_MAX_W'(1);
    return ones_v & ~(FP_MAX_W'(1) << frac_w);
  endfunction

  function automatic logic [FP_MAX_W-1:0] default_qnan(input int unsigned exp_w,
                                                       input int unsigned frac_w);
    logic [FP_MAX_W-1:0] top_v;
    top_v = ((FP_MAX_W'(1) << (exp_w + 1)) - FP_MAX_W'(1)) << frac_w;
    return top_v | (FP_MAX_W'(1) << (frac_w - 1));
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Issue/result handshake bundle between the FPU micro-sequencer, the multiply pipe and writeback.
interface fp_mul_pipe_if #(
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 52,
  parameter int TAG_W  = 4
) ();
  localparam int W = 1 + EXP_W + FRAC_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [1:0]       in_rc;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_y;
  logic [TAG_W-1:0] out_tag;
  logic [4:0]       out_flags;

  modport master (
    output in_valid, in_a, in_b, in_rc, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_y, out_tag, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_rc, in_tag, flush, out_ready,
    output in_ready, out_valid, out_y, out_tag, out_flags
  );
endinterface

// File: rtl/fp_round_sel.sv
// Combinational rounding and overflow/underflow detection for a normalised significand.
module fp_round_sel
  import fpu_pkg::*;
#(
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 52
) (
  input  logic              sign,
  input  logic [1:0]        rc,
  input  logic [FRAC_W:0]   sig_in,
  input  logic              g,
  input  logic              r,
  input  logic              s,
  input  logic [EXP_W+2:0]  exp_in,
  output logic [FRAC_W-1:0] frac_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              overflow,
  output logic              underflow,
  output logic              ovf_to_inf
);
  localparam int XW = EXP_W + 3;
  localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(exp_all_ones(EXP_W));

  logic              inc;
  logic              lost;
  logic [FRAC_W+1:0] sum;
  logic [XW-1:0]     exp_r;

  always_comb begin
    inc        = 1'b0;
    ovf_to_inf = 1'b1;
    lost       = g | r | s;
    case (rc)
      RC_RN: inc = g & (r | s | sig_in[0]);
      RC_RD: begin inc = sign & lost;  ovf_to_inf = sign;  end
      RC_RU: begin inc = !sign & lost; ovf_to_inf = !sign; end
      RC_RZ: ovf_to_inf = 1'b0;
    endcase

    sum      = {1'b0, sig_in} + {{(FRAC_W+1){1'b0}}, inc};
    // Carry only happens from an all-ones significand, so the shifted result is exactly 1.0.
    frac_out = sum[FRAC_W+1] ? sum[FRAC_W:1] : sum[FRAC_W-1:0];
    exp_r    = exp_in + {{(XW-1){1'b0}}, sum[FRAC_W+1]};
    exp_out  = exp_r[EXP_W-1:0];

    underflow = exp_r[XW-1] | (exp_r == '0);
    overflow  = !exp_r[XW-1] & (exp_r >= {3'b000, EXP_ONES});
  end
endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier: S1 classify/multiply, S2 normalise/round,
// S3 pack/special select. A single global advance stalls every stage together.
module fp_mul_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 52,
  parameter int TAG_W  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  fp_mul_pipe_if.slave  bus
);
  localparam int W     = 1 + EXP_W + FRAC_W;
  localparam int SIG_W = FRAC_W + 1;
  localparam int PW    = 2 * SIG_W;
  localparam int XW    = EXP_W + 3;
  localparam logic [EXP_W-1:0]    EXP_ONES  = EXP_W'(exp_all_ones(EXP_W));
  localparam logic [XW-1:0]       BIAS_X    = XW'(exp_bias(EXP_W));
  localparam logic [FP_MAX_W-1:0] MAXF_WIDE = max_finite(EXP_W, FRAC_W);
  localparam logic [FP_MAX_W-1:0] QNAN_WIDE = default_qnan(EXP_W, FRAC_W);

  typedef struct packed {
    logic             sign;
    logic [1:0]       rc;
    logic [TAG_W-1:0] tag;
    logic [XW-1:0]    exp;
    logic [PW-1:0]    prod;
    logic             special;
    logic [W-1:0]     spec_y;
    logic [4:0]       flags;
  } s1_t;

  typedef struct packed {
    logic              sign;
    logic [TAG_W-1:0]  tag;
    logic              special;
    logic [W-1:0]      spec_y;
    logic [4:0]        flags;
    logic [FRAC_W-1:0] frac;
    logic [EXP_W-1:0]  exp;
    logic              ovf;
    logic              unf;
    logic              ovf_inf;
    logic              lost;
  } s2_t;

  s1_t s1_q, s1_d, s1_n;
  s2_t s2_q, s2_d, s2_n;
  logic v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
  logic [W-1:0]     out_y_q, out_y_d, y_n;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [4:0]       out_flags_q, out_flags_d, flags_n;
  logic             adv;

  logic              a_sign, b_sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [EXP_W-1:0]  a_exp, b_exp;
  logic [FRAC_W-1:0] a_frac, b_frac;
  logic [W-1:0]      nan_pick;

  logic [PW-1:0]     norm;
  logic [XW-1:0]     exp_n;
  logic              g, r, s;
  logic [FRAC_W-1:0] r_frac;
  logic [EXP_W-1:0]  r_exp;
  logic              r_ovf, r_unf, r_ovf_inf;

  always_comb begin
    {a_sign, a_exp, a_frac} = bus.in_a;
    {b_sign, b_exp, b_frac} = bus.in_b;
    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
    b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
    a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
    b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
    nan_pick = a_nan ? bus.in_a : bus.in_b;

    s1_n      = '0;
    s1_n.sign = a_sign ^ b_sign;
    s1_n.rc   = bus.in_rc;
    s1_n.tag  = bus.in_tag;
    s1_n.exp  = {3'b000, a_exp} + {3'b000, b_exp} - BIAS_X;
    s1_n.prod = {{SIG_W{1'b0}}, 1'b1, a_frac} * {{SIG_W{1'b0}}, 1'b1, b_frac};
    s1_n.flags[FLAG_DEN] = (a_zero && a_frac != '0) || (b_zero && b_frac != '0);
    s1_n.special = 1'b1;
    if (a_nan || b_nan) begin
      s1_n.spec_y             = nan_pick;
      s1_n.spec_y[FRAC_W-1]   = 1'b1;
      s1_n.flags[FLAG_INV]    = !nan_pick[FRAC_W-1];
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      s1_n.spec_y          = QNAN_WIDE[W-1:0];
      s1_n.flags[FLAG_INV] = 1'b1;
    end else if (a_inf || b_inf) begin
      s1_n.spec_y = {s1_n.sign, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      s1_n.spec_y = {s1_n.sign, {(W-1){1'b0}}};
    end else begin
      s1_n.special = 1'b0;
    end
  end

  // Product of two 1.x significands lies in [1,4): at most one position of normalisation.
  always_comb begin
    norm  = s1_q.prod[PW-1] ? s1_q.prod : {s1_q.prod[PW-2:0], 1'b0};
    exp_n = s1_q.exp + {{(XW-1){1'b0}}, s1_q.prod[PW-1]};
    g     = norm[PW-1-SIG_W];
    r     = norm[PW-2-SIG_W];
    s     = |norm[PW-3-SIG_W:0];
  end

  fp_round_sel #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_round (
    .sign       (s1_q.sign),
    .rc         (s1_q.rc),
    .sig_in     (norm[PW-1 -: SIG_W]),
    .g          (g),
    .r          (r),
    .s          (s),
    .exp_in     (exp_n),
    .frac_out   (r_frac),
    .exp_out    (r_exp),
    .overflow   (r_ovf),
    .underflow  (r_unf),
    .ovf_to_inf (r_ovf_inf)
  );

  always_comb begin
    s2_n         = '0;
    s2_n.sign    = s1_q.sign;
    s2_n.tag     = s1_q.tag;
    s2_n.special = s1_q.special;
    s2_n.spec_y  = s1_q.spec_y;
    s2_n.flags   = s1_q.flags;
    s2_n.frac    = r_frac;
    s2_n.exp     = r_exp;
    s2_n.ovf     = r_ovf;
    s2_n.unf     = r_unf;
    s2_n.ovf_inf = r_ovf_inf;
    s2_n.lost    = g | r | s;
  end

  always_comb begin
    y_n     = {s2_q.sign, s2_q.exp, s2_q.frac};
    flags_n = s2_q.flags;
    if (s2_q.special) begin
      y_n = s2_q.spec_y;
    end else if (s2_q.ovf) begin
      flags_n[FLAG_OVF] = 1'b1;
      flags_n[FLAG_INX] = 1'b1;
      y_n = s2_q.ovf_inf ? {s2_q.sign, EXP_ONES, {FRAC_W{1'b0}}}
                         : {s2_q.sign, MAXF_WIDE[W-2:0]};
    end else if (s2_q.unf) begin
      flags_n[FLAG_UNF] = 1'b1;
      flags_n[FLAG_INX] = 1'b1;
      y_n = {s2_q.sign, {(W-1){1'b0}}};
    end else begin
      flags_n[FLAG_INX] = s2_q.lost;
    end
  end

  always_comb begin
    adv         = !out_valid_q || bus.out_ready;
    v1_d        = v1_q;
    v2_d        = v2_q;
    out_valid_d = out_valid_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    out_y_d     = out_y_q;
    out_tag_d   = out_tag_q;
    out_flags_d = out_flags_q;
    if (adv) begin
      s1_d        = s1_n;
      s2_d        = s2_n;
      out_y_d     = y_n;
      out_tag_d   = s2_q.tag;
      out_flags_d = flags_n;
      v1_d        = bus.in_valid;
      v2_d        = v1_q;
      out_valid_d = v2_q;
    end
    if (bus.flush) begin
      v1_d        = 1'b0;
      v2_d        = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      out_y_q     <= '0;
      out_tag_q   <= '0;
      out_flags_q <= '0;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      out_y_q     <= out_y_d;
      out_tag_q   <= out_tag_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_flags = out_flags_q;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe in the FP64 configuration.
module tb_fp_mul_pipe;
  localparam int EXP_W  = 11;
  localparam int FRAC_W = 52;
  localparam int TAG_W  = 4;

  localparam logic [4:0] F_INV = 5'b10000;
  localparam logic [4:0] F_DEN = 5'b01000;
  localparam logic [4:0] F_OVF = 5'b00100;
  localparam logic [4:0] F_UNF = 5'b00010;
  localparam logic [4:0] F_INX = 5'b00001;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_mul_pipe_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) bus ();

  fp_mul_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  rc;
    logic [63:0] y;
    logic [4:0]  f;
  } vec_t;

  typedef struct {
    logic [63:0] y;
    logic [4:0]  f;
    logic [3:0]  tag;
    int          issue_cyc;
    bit          chk_lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int n_pass = 0;
  int n_checks = 0;
  int cyc = 0;
  int n_out = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, obs, expv);
  endtask

  task automatic add(input logic [63:0] a, input logic [63:0] b, input logic [1:0] rc,
                     input logic [63:0] y, input logic [4:0] f);
    vec_t v;
    v.a = a; v.b = b; v.rc = rc; v.y = y; v.f = f;
    vecs.push_back(v);
  endtask

  // One clock: drive at negedge, sample 1 time unit later, account for both handshakes.
  task automatic step(input bit iv, input int vi, input logic [3:0] tag, input bit ordy,
                      input bit fl, input bit lat, output bit acc);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_a      = vecs[vi].a;
    bus.in_b      = vecs[vi].b;
    bus.in_rc     = vecs[vi].rc;
    bus.in_tag    = tag;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    acc = iv && bus.in_ready && !fl;
    if (bus.out_valid && ordy) begin
      n_out++;
      chk("out_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("y", bus.out_y, e.y);
        chk("flags", 64'(bus.out_flags), 64'(e.f));
        chk("tag", 64'(bus.out_tag), 64'(e.tag));
        if (e.chk_lat) chk("latency", 64'(cyc - e.issue_cyc), 64'd3);
      end
    end
    if (fl) sb.delete();
    if (acc) begin
      e.y = vecs[vi].y; e.f = vecs[vi].f; e.tag = tag;
      e.issue_cyc = cyc; e.chk_lat = lat;
      sb.push_back(e);
    end
    cyc++;
  endtask

  task automatic issue(input int vi, input logic [3:0] tag, input bit rnd_rdy);
    bit acc = 1'b0;
    int guard = 0;
    while (!acc && guard < 50) begin
      step(1'b1, vi, tag, rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0, acc);
      guard++;
    end
    chk("issue_accepted", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    bit acc;
    int guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      step(1'b0, 0, 4'd0, 1'b1, 1'b0, 1'b0, acc);
      guard++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 0, 4'd0, 1'b1, 1'b0, 1'b0, acc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int k;
    int n0;
    int bp_idx[5];

    add(64'h3FF8000000000000, 64'h4000000000000000, 2'b00, 64'h4008000000000000, 5'b0);
    add(64'h3FF0000000000001, 64'h3FF0000000000001, 2'b00, 64'h3FF0000000000002, F_INX);
    add(64'h3FF0000000000001, 64'h3FF0000000000001, 2'b10, 64'h3FF0000000000003, F_INX);
    add(64'h3FF0000000000001, 64'h3FF0000000000001, 2'b11, 64'h3FF0000000000002, F_INX);
    add(64'h3FF0000000000001, 64'h3FF0000000000001, 2'b01, 64'h3FF0000000000002, F_INX);
    add(64'hBFF0000000000001, 64'h3FF0000000000001, 2'b01, 64'hBFF0000000000003, F_INX);
    add(64'h7FE0000000000000, 64'h4000000000000000, 2'b00, 64'h7FF0000000000000, F_OVF | F_INX);
    add(64'h7FE0000000000000, 64'h4000000000000000, 2'b11, 64'h7FEFFFFFFFFFFFFF, F_OVF | F_INX);
    add(64'hFFE0000000000000, 64'h4000000000000000, 2'b10, 64'hFFEFFFFFFFFFFFFF, F_OVF | F_INX);
    add(64'hFFE0000000000000, 64'h4000000000000000, 2'b01, 64'hFFF0000000000000, F_OVF | F_INX);
    add(64'h7FE0000000000000, 64'h4000000000000000, 2'b10, 64'h7FF0000000000000, F_OVF | F_INX);
    add(64'h7FE0000000000000, 64'h4000000000000000, 2'b01, 64'h7FEFFFFFFFFFFFFF, F_OVF | F_INX);
    add(64'h7FF0000000000000, 64'h0000000000000000, 2'b00, 64'hFFF8000000000000, F_INV);
    add(64'h7FF0000000000001, 64'h3FF0000000000000, 2'b00, 64'h7FF8000000000001, F_INV);
    add(64'h3FF0000000000000, 64'h7FF8000000000005, 2'b00, 64'h7FF8000000000005, 5'b0);
    add(64'h8000000000000001, 64'h3FF0000000000000, 2'b00, 64'h8000000000000000, F_DEN);
    add(64'h0010000000000000, 64'h3FE0000000000000, 2'b00, 64'h0000000000000000, F_UNF | F_INX);
    add(64'h3FF0000000000001, 64'h3FF8000000000000, 2'b00, 64'h3FF8000000000002, F_INX);
    add(64'h3FF0000000000001, 64'h3FF8000000000000, 2'b11, 64'h3FF8000000000001, F_INX);
    add(64'h7FF0000000000000, 64'hC000000000000000, 2'b00, 64'hFFF0000000000000, 5'b0);
    add(64'h8000000000000000, 64'h4000000000000000, 2'b00, 64'h8000000000000000, 5'b0);

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_rc = '0; bus.in_tag = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_y", bus.out_y, 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_out_flags", 64'(bus.out_flags), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single op into an idle pipe: latency and tag echo.
    step(1'b1, 0, 4'hA, 1'b1, 1'b0, 1'b1, acc);
    chk("lat_issue_accepted", 64'(acc), 64'd1);
    drain();

    // Back-to-back, no stall, then again under random backpressure.
    for (int i = 0; i < vecs.size(); i++) issue(i, 4'(i), 1'b0);
    drain();
    for (int i = 0; i < vecs.size(); i++) issue(i, 4'(i + 3), 1'b1);
    drain();

    // Five ops with the consumer stalled: only three fit.
    bp_idx = '{0, 1, 6, 12, 17};
    k = 0;
    for (int c = 0; c < 8; c++) begin
      step(k < 5, (k < 5) ? bp_idx[k] : 0, 4'(k + 1), 1'b0, 1'b0, 1'b0, acc);
      if (acc) k++;
    end
    chk("bp_accepted", 64'(k), 64'd3);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    n0 = n_out;
    for (int c = 0; c < 30 && (k < 5 || sb.size() > 0); c++) begin
      step(k < 5, (k < 5) ? bp_idx[k] : 0, 4'(k + 1), 1'b1, 1'b0, 1'b0, acc);
      if (acc) k++;
    end
    chk("bp_delivered", 64'(n_out - n0), 64'd5);
    drain();

    // Flush with two ops in flight and a third presented in the same cycle.
    step(1'b1, 1, 4'd6, 1'b1, 1'b0, 1'b0, acc);
    step(1'b1, 2, 4'd7, 1'b1, 1'b0, 1'b0, acc);
    step(1'b1, 3, 4'd8, 1'b1, 1'b1, 1'b0, acc);
    n0 = n_out;
    idle(6);
    chk("flush_silence", 64'(n_out - n0), 64'd0);
    issue(13, 4'd9, 1'b0);
    drain();

    // Asynchronous reset with the pipe full and the consumer stalled.
    step(1'b1, 0, 4'd1, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 1, 4'd2, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 2, 4'd3, 1'b0, 1'b0, 1'b0, acc);
    step(1'b0, 0, 4'd0, 1'b0, 1'b0, 1'b0, acc);
    chk("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    n0 = n_out;
    idle(6);
    chk("rst_silence", 64'(n_out - n0), 64'd0);
    issue(16, 4'd5, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
